// File: rtl/spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : spi_txn_sequencer
// Purpose  : Feeds buffered command words to the 16-bit SPI master one at a
//            time and collects the received words into a response FIFO.
// Revision : 1.0 - initial release
// ============================================================================
module spi_txn_sequencer #(
    parameter int CMD_DEPTH      = 4,
    parameter int RSP_DEPTH      = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [15:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_data,
    output logic        rsp_err,
    output logic [15:0] m_data_in,
    input  logic        m_spi_cs,
    input  logic [15:0] m_spi_data,
    output logic        busy,
    output logic        zero_cmd
);

    localparam int c_cmd_aw = $clog2(CMD_DEPTH);
    localparam int c_rsp_aw = $clog2(RSP_DEPTH);
    localparam logic [c_cmd_aw:0] c_cmd_full = CMD_DEPTH[c_cmd_aw:0];
    localparam logic [c_rsp_aw:0] c_rsp_full = RSP_DEPTH[c_rsp_aw:0];
    localparam logic [15:0]       c_tmo_last = 16'(TIMEOUT_CYCLES - 1);

    localparam logic [2:0] c_st_idle   = 3'd0;
    localparam logic [2:0] c_st_issue  = 3'd1;
    localparam logic [2:0] c_st_active = 3'd2;
    localparam logic [2:0] c_st_abort  = 3'd3;
    localparam logic [2:0] c_st_drain  = 3'd4;

    logic [15:0]         r_cmd_mem [CMD_DEPTH];
    logic [c_cmd_aw-1:0] r_cmd_wr_ptr;
    logic [c_cmd_aw-1:0] r_cmd_rd_ptr;
    logic [c_cmd_aw:0]   r_cmd_count;
    logic                r_zero_cmd;

    logic [15:0]         r_rsp_data_mem [RSP_DEPTH];
    logic                r_rsp_err_mem  [RSP_DEPTH];
    logic [c_rsp_aw-1:0] r_rsp_wr_ptr;
    logic [c_rsp_aw-1:0] r_rsp_rd_ptr;
    logic [c_rsp_aw:0]   r_rsp_count;

    logic [2:0]          r_state;
    logic [15:0]         r_timer;
    logic [1:0]          r_cs_hi_cnt;
    logic [15:0]         r_m_data_in;
    logic                r_busy;

    logic                w_cmd_accept;
    logic                w_cmd_push;
    logic                w_cmd_pop;
    logic                w_cmd_empty;
    logic                w_rsp_space;
    logic                w_rsp_push;
    logic                w_rsp_pop;
    logic                w_rsp_push_err;
    logic [15:0]         w_rsp_push_data;
    logic                w_tmo;

    assign cmd_ready    = (r_cmd_count != c_cmd_full);
    assign w_cmd_empty  = (r_cmd_count == '0);
    assign w_cmd_accept = cmd_valid && cmd_ready;
    // Zero means "no request" to the master, so it is acknowledged but never queued
    assign w_cmd_push   = w_cmd_accept && (cmd_data != 16'h0000);

    // In IDLE nothing is in flight, so one free slot is the whole reservation
    assign w_rsp_space  = (r_rsp_count < c_rsp_full);
    assign w_cmd_pop    = (r_state == c_st_idle) && !w_cmd_empty && w_rsp_space;

    assign w_rsp_push      = ((r_state == c_st_active) && m_spi_cs) || (r_state == c_st_abort);
    assign w_rsp_push_err  = (r_state == c_st_abort);
    assign w_rsp_push_data = w_rsp_push_err ? 16'h0000 : m_spi_data;
    assign w_rsp_pop       = rsp_valid && rsp_ready;

    assign w_tmo = (r_timer >= c_tmo_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CMD_DEPTH; i++) begin
                r_cmd_mem[i] <= '0;
            end
            r_cmd_wr_ptr <= '0;
            r_cmd_rd_ptr <= '0;
            r_cmd_count  <= '0;
            r_zero_cmd   <= 1'b0;
        end else begin
            if (w_cmd_push) begin
                r_cmd_mem[r_cmd_wr_ptr] <= cmd_data;
                r_cmd_wr_ptr            <= r_cmd_wr_ptr + 1'b1;
            end
            if (w_cmd_pop) begin
                r_cmd_rd_ptr <= r_cmd_rd_ptr + 1'b1;
            end
            case ({w_cmd_push, w_cmd_pop})
                2'b10:   r_cmd_count <= r_cmd_count + 1'b1;
                2'b01:   r_cmd_count <= r_cmd_count - 1'b1;
                default: r_cmd_count <= r_cmd_count;
            endcase
            r_zero_cmd <= w_cmd_accept && (cmd_data == 16'h0000);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_rsp_data_mem[i] <= '0;
                r_rsp_err_mem[i]  <= 1'b0;
            end
            r_rsp_wr_ptr <= '0;
            r_rsp_rd_ptr <= '0;
            r_rsp_count  <= '0;
        end else begin
            if (w_rsp_push) begin
                r_rsp_data_mem[r_rsp_wr_ptr] <= w_rsp_push_data;
                r_rsp_err_mem[r_rsp_wr_ptr]  <= w_rsp_push_err;
                r_rsp_wr_ptr                 <= r_rsp_wr_ptr + 1'b1;
            end
            if (w_rsp_pop) begin
                r_rsp_rd_ptr <= r_rsp_rd_ptr + 1'b1;
            end
            case ({w_rsp_push, w_rsp_pop})
                2'b10:   r_rsp_count <= r_rsp_count + 1'b1;
                2'b01:   r_rsp_count <= r_rsp_count - 1'b1;
                default: r_rsp_count <= r_rsp_count;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_st_idle;
            r_timer     <= '0;
            r_cs_hi_cnt <= '0;
            r_m_data_in <= '0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    r_m_data_in <= '0;
                    if (w_cmd_pop) begin
                        r_m_data_in <= r_cmd_mem[r_cmd_rd_ptr];
                        r_timer     <= '0;
                        r_busy      <= 1'b1;
                        r_state     <= c_st_issue;
                    end
                end
                c_st_issue: begin
                    r_timer <= r_timer + 1'b1;
                    if (!m_spi_cs) begin
                        r_m_data_in <= '0;
                        r_state     <= c_st_active;
                    end else if (w_tmo) begin
                        r_m_data_in <= '0;
                        r_state     <= c_st_abort;
                    end
                end
                c_st_active: begin
                    r_timer <= r_timer + 1'b1;
                    if (m_spi_cs) begin
                        r_busy  <= 1'b0;
                        r_state <= c_st_idle;
                    end else if (w_tmo) begin
                        r_state <= c_st_abort;
                    end
                end
                c_st_abort: begin
                    r_m_data_in <= '0;
                    r_cs_hi_cnt <= '0;
                    r_state     <= c_st_drain;
                end
                c_st_drain: begin
                    // A late or in-progress transfer must finish before the next word goes out
                    r_m_data_in <= '0;
                    if (m_spi_cs) begin
                        if (r_cs_hi_cnt == 2'd3) begin
                            r_busy  <= 1'b0;
                            r_state <= c_st_idle;
                        end else begin
                            r_cs_hi_cnt <= r_cs_hi_cnt + 1'b1;
                        end
                    end else begin
                        r_cs_hi_cnt <= '0;
                    end
                end
                default: begin
                    r_m_data_in <= '0;
                    r_busy      <= 1'b0;
                    r_state     <= c_st_idle;
                end
            endcase
        end
    end

    assign rsp_valid = (r_rsp_count != '0);
    assign rsp_data  = r_rsp_data_mem[r_rsp_rd_ptr];
    assign rsp_err   = r_rsp_err_mem[r_rsp_rd_ptr];
    assign m_data_in = r_m_data_in;
    assign busy      = r_busy;
    assign zero_cmd  = r_zero_cmd;

endmodule
`default_nettype wire

// File: tb/tb_spi_txn_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_txn_sequencer
// Purpose  : Self-checking bench with an SPI master/slave model and a queue
//            based reference of command and response ordering.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_txn_sequencer;

    localparam int c_xfer_low = 68;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err, busy, zero_cmd;
    logic [15:0] cmd_data, rsp_data, m_data_in, m_spi_data;
    logic        m_spi_cs;

    logic        t_cmd_valid, t_cmd_ready, t_rsp_valid, t_rsp_ready, t_rsp_err, t_busy, t_zero_cmd;
    logic [15:0] t_cmd_data, t_rsp_data, t_m_data_in, t_spi_data;
    logic        t_cs;

    int n_cmp = 0;
    int n_err = 0;
    int xfer_count = 0;
    int zero_seen = 0;
    int load_count = 0;
    logic [15:0] last_mdi = '0;
    int mst_st = 0;
    int mst_cnt = 0;
    logic [15:0] mst_word = '0;

    always #5 clk = ~clk;

    spi_txn_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(255)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .m_data_in(m_data_in), .m_spi_cs(m_spi_cs), .m_spi_data(m_spi_data),
        .busy(busy), .zero_cmd(zero_cmd));

    spi_txn_sequencer #(.CMD_DEPTH(4), .RSP_DEPTH(4), .TIMEOUT_CYCLES(16)) dut_tmo (
        .clk(clk), .rst(rst), .cmd_valid(t_cmd_valid), .cmd_ready(t_cmd_ready), .cmd_data(t_cmd_data),
        .rsp_valid(t_rsp_valid), .rsp_ready(t_rsp_ready), .rsp_data(t_rsp_data), .rsp_err(t_rsp_err),
        .m_data_in(t_m_data_in), .m_spi_cs(t_cs), .m_spi_data(t_spi_data),
        .busy(t_busy), .zero_cmd(t_zero_cmd));

    // Slave reply: inverted, byte-swapped copy of the word sent (A5C3 -> 3C5A)
    function automatic logic [15:0] resp_of(input logic [15:0] w);
        logic [15:0] n;
        n = ~w;
        return {n[7:0], n[15:8]};
    endfunction

    // Master model: idle sees nonzero data_in, cs falls two cycles after it appears
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_spi_cs   <= 1'b1;
            m_spi_data <= '0;
            mst_st     <= 0;
            mst_cnt    <= 0;
        end else begin
            case (mst_st)
                0: if (m_data_in != 16'h0000) begin mst_word <= m_data_in; mst_st <= 1; end
                1: begin m_spi_cs <= 1'b0; mst_cnt <= 0; mst_st <= 2; xfer_count <= xfer_count + 1; end
                2: if (mst_cnt == c_xfer_low - 1) begin
                       m_spi_cs   <= 1'b1;
                       m_spi_data <= resp_of(mst_word);
                       mst_st     <= 3;
                   end else begin
                       mst_cnt <= mst_cnt + 1;
                   end
                default: mst_st <= 0;
            endcase
        end
    end

    always @(posedge clk) begin
        #1;
        if (zero_cmd) zero_seen++;
        if (m_data_in != 16'h0000 && last_mdi == 16'h0000) load_count++;
        last_mdi = m_data_in;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish earlier", $time);
        $fatal(1);
    end

    task automatic push_a(input logic [15:0] w, output int stalls);
        stalls = 0;
        cmd_valid = 1'b1;
        cmd_data  = w;
        while (!cmd_ready && stalls < 2000) begin
            @(negedge clk);
            stalls++;
        end
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_data  = '0;
    endtask

    task automatic pop_a(output logic [15:0] d, output logic e, output bit ok);
        int n;
        n = 0;
        while (!rsp_valid && n < 3000) begin
            @(negedge clk);
            n++;
        end
        ok = rsp_valid;
        d  = rsp_data;
        e  = rsp_err;
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        n_cmp++; if (m_data_in !== 16'h0) begin n_err++; $display("FAIL reset_m_data_in: got %h want 0000", m_data_in); end
        n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_cmp++; if (zero_cmd !== 1'b0) begin n_err++; $display("FAIL reset_zero_cmd: got %b want 0", zero_cmd); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", rsp_valid); end
        n_cmp++; if (rsp_data !== 16'h0 || rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_head: got %h/%b want 0000/0", rsp_data, rsp_err); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", cmd_ready); end
        n_cmp++; if (t_cmd_ready !== 1'b1 || t_busy !== 1'b0) begin n_err++; $display("FAIL reset_tmo_inst: got ready=%b busy=%b want 1/0", t_cmd_ready, t_busy); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0) begin n_err++; $display("FAIL post_reset_idle: got busy=%b rsp_valid=%b want 0/0", busy, rsp_valid); end
    endtask

    task automatic test_single();
        int stalls, n;
        bit hold_ok;
        logic [15:0] d;
        logic e;
        bit ok;
        push_a(16'hA5C3, stalls);
        hold_ok = 1'b1;
        n = 0;
        while (m_spi_cs && n < 50) begin
            if (busy && m_data_in !== 16'hA5C3) hold_ok = 1'b0;
            @(negedge clk);
            n++;
        end
        n_cmp++; if (!hold_ok || m_spi_cs !== 1'b0) begin n_err++; $display("FAIL single_hold: got hold_ok=%b cs=%b want 1/0", hold_ok, m_spi_cs); end
        n_cmp++; if (m_data_in !== 16'hA5C3) begin n_err++; $display("FAIL single_at_cs_fall: got %h want a5c3", m_data_in); end
        @(negedge clk);
        n_cmp++; if (m_data_in !== 16'h0000) begin n_err++; $display("FAIL single_cleared: got %h want 0000", m_data_in); end
        n = 0;
        while (!m_spi_cs && n < 200) begin
            @(negedge clk);
            n++;
        end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_early: got %b want 0", rsp_valid); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL single_rsp_latency: got %b want 1", rsp_valid); end
        pop_a(d, e, ok);
        n_cmp++; if (!ok || d !== 16'h3C5A || e !== 1'b0) begin n_err++; $display("FAIL single_rsp: got ok=%b %h/%b want 3c5a/0", ok, d, e); end
        @(negedge clk);
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL single_rsp_drained: got %b want 0", rsp_valid); end
    endtask

    task automatic test_zero_word();
        int stalls, z0, x0;
        logic [15:0] d;
        logic e;
        bit ok;
        z0 = zero_seen;
        x0 = xfer_count;
        push_a(16'h1111, stalls);
        push_a(16'h0000, stalls);
        n_cmp++; if (zero_cmd !== 1'b1) begin n_err++; $display("FAIL zero_pulse: got %b want 1", zero_cmd); end
        push_a(16'h2222, stalls);
        n_cmp++; if (zero_cmd !== 1'b0) begin n_err++; $display("FAIL zero_pulse_width: got %b want 0", zero_cmd); end
        pop_a(d, e, ok);
        n_cmp++; if (!ok || d !== resp_of(16'h1111) || e !== 1'b0) begin n_err++; $display("FAIL zero_rsp0: got %h/%b want %h/0", d, e, resp_of(16'h1111)); end
        pop_a(d, e, ok);
        n_cmp++; if (!ok || d !== resp_of(16'h2222) || e !== 1'b0) begin n_err++; $display("FAIL zero_rsp1: got %h/%b want %h/0", d, e, resp_of(16'h2222)); end
        repeat (100) @(negedge clk);
        n_cmp++; if (xfer_count - x0 !== 2) begin n_err++; $display("FAIL zero_xfers: got %0d want 2", xfer_count - x0); end
        n_cmp++; if (zero_seen - z0 !== 1) begin n_err++; $display("FAIL zero_count: got %0d want 1", zero_seen - z0); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL zero_no_extra_rsp: got %b want 0", rsp_valid); end
    endtask

    task automatic test_backpressure();
        logic [15:0] words [6];
        int stalls, x0, l0, occ, n;
        logic [15:0] d;
        logic e;
        bit ok;
        rsp_ready = 1'b0;
        x0 = xfer_count;
        l0 = load_count;
        for (int i = 0; i < 6; i++) words[i] = 16'($urandom_range(1, 65535));
        for (int i = 0; i < 6; i++) begin
            occ = i - (load_count - l0);
            n_cmp++;
            if (cmd_ready !== (occ < 4)) begin n_err++; $display("FAIL bp_cmd_ready[%0d]: got %b want %b", i, cmd_ready, (occ < 4)); end
            push_a(words[i], stalls);
        end
        n = 0;
        while (xfer_count - x0 < 4 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        repeat (300) @(negedge clk);
        n_cmp++; if (xfer_count - x0 !== 4) begin n_err++; $display("FAIL bp_xfers_held: got %0d want 4", xfer_count - x0); end
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b1) begin n_err++; $display("FAIL bp_stalled: got busy=%b rsp_valid=%b want 0/1", busy, rsp_valid); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_cmd_left: got %b want 1", cmd_ready); end
        for (int i = 0; i < 6; i++) begin
            pop_a(d, e, ok);
            n_cmp++;
            if (!ok || d !== resp_of(words[i]) || e !== 1'b0) begin n_err++; $display("FAIL bp_rsp[%0d]: got ok=%b %h/%b want %h/0", i, ok, d, e, resp_of(words[i])); end
        end
        repeat (20) @(negedge clk);
        n_cmp++; if (xfer_count - x0 !== 6) begin n_err++; $display("FAIL bp_xfers_total: got %0d want 6", xfer_count - x0); end
    endtask

    task automatic test_random();
        logic [15:0] words [10];
        int z, z0;
        z = 0;
        for (int i = 0; i < 10; i++) begin
            words[i] = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom_range(1, 65535));
            if (words[i] == 16'h0000) z++;
        end
        z0 = zero_seen;
        fork
            begin
                int stalls;
                for (int i = 0; i < 10; i++) push_a(words[i], stalls);
            end
            begin
                logic [15:0] d;
                logic e;
                bit ok;
                for (int i = 0; i < 10; i++) begin
                    if (words[i] != 16'h0000) begin
                        repeat ($urandom_range(0, 40)) @(negedge clk);
                        pop_a(d, e, ok);
                        n_cmp++;
                        if (!ok || d !== resp_of(words[i]) || e !== 1'b0) begin
                            n_err++;
                            $display("FAIL rand_rsp[%0d]: got ok=%b %h/%b want %h/0", i, ok, d, e, resp_of(words[i]));
                        end
                    end
                end
            end
        join
        repeat (10) @(negedge clk);
        n_cmp++; if (zero_seen - z0 !== z) begin n_err++; $display("FAIL rand_zero_count: got %0d want %0d", zero_seen - z0, z); end
        n_cmp++; if (rsp_valid !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL rand_quiet: got rsp_valid=%b busy=%b want 0/0", rsp_valid, busy); end
    endtask

    task automatic test_timeout();
        int n, issue_cyc, post_cyc;
        t_cs = 1'b1;
        t_spi_data = 16'($urandom);
        t_cmd_valid = 1'b1;
        t_cmd_data  = 16'h00FF;
        @(negedge clk);
        t_cmd_valid = 1'b0;
        t_cmd_data  = '0;
        n = 0;
        while (!t_busy && n < 20) begin @(negedge clk); n++; end
        issue_cyc = 0;
        post_cyc  = 0;
        n = 0;
        while (t_busy && n < 200) begin
            if (t_m_data_in == 16'h00FF) issue_cyc++;
            else if (t_m_data_in == 16'h0000) post_cyc++;
            @(negedge clk);
            n++;
        end
        n_cmp++; if (issue_cyc !== 16) begin n_err++; $display("FAIL tmo_issue_cycles: got %0d want 16", issue_cyc); end
        n_cmp++; if (post_cyc !== 5) begin n_err++; $display("FAIL tmo_abort_drain_cycles: got %0d want 5", post_cyc); end
        n_cmp++; if (t_rsp_valid !== 1'b1 || t_rsp_data !== 16'h0000 || t_rsp_err !== 1'b1) begin
            n_err++; $display("FAIL tmo_rsp: got v=%b %h/%b want 1 0000/1", t_rsp_valid, t_rsp_data, t_rsp_err);
        end
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        n_cmp++; if (t_rsp_valid !== 1'b0) begin n_err++; $display("FAIL tmo_rsp_single: got %b want 0", t_rsp_valid); end
    endtask

    task automatic test_late_start();
        int n, c;
        bit held;
        t_cs = 1'b1;
        t_cmd_valid = 1'b1;
        t_cmd_data  = 16'($urandom_range(1, 65535));
        @(negedge clk);
        t_cmd_valid = 1'b0;
        t_cmd_data  = '0;
        n = 0;
        while (!(t_busy && t_m_data_in == 16'h0000) && n < 100) begin @(negedge clk); n++; end
        @(negedge clk);
        t_cs = 1'b0;
        held = 1'b1;
        for (int i = 0; i < 70; i++) begin
            t_spi_data = 16'($urandom);
            @(negedge clk);
            if (!t_busy || t_m_data_in !== 16'h0000) held = 1'b0;
        end
        n_cmp++; if (!held) begin n_err++; $display("FAIL late_drain_held: got held=%b want 1", held); end
        t_cs = 1'b1;
        c = 0;
        while (t_busy && c < 20) begin c++; @(negedge clk); end
        n_cmp++; if (c !== 4) begin n_err++; $display("FAIL late_idle_after_cs_high: got %0d want 4", c); end
        n_cmp++; if (t_rsp_valid !== 1'b1 || t_rsp_data !== 16'h0000 || t_rsp_err !== 1'b1) begin
            n_err++; $display("FAIL late_rsp: got v=%b %h/%b want 1 0000/1", t_rsp_valid, t_rsp_data, t_rsp_err);
        end
        t_rsp_ready = 1'b1;
        @(negedge clk);
        t_rsp_ready = 1'b0;
        repeat (10) @(negedge clk);
        n_cmp++; if (t_rsp_valid !== 1'b0) begin n_err++; $display("FAIL late_no_extra_rsp: got %b want 0", t_rsp_valid); end
    endtask

    task automatic test_reset_mid();
        int stalls, n, x0;
        push_a(16'($urandom_range(1, 65535)), stalls);
        n = 0;
        while (!rsp_valid && n < 300) begin @(negedge clk); n++; end
        for (int i = 0; i < 3; i++) push_a(16'($urandom_range(1, 65535)), stalls);
        n = 0;
        while (m_spi_cs && n < 300) begin @(negedge clk); n++; end
        repeat (30) @(negedge clk);
        n_cmp++; if (busy !== 1'b1 || m_spi_cs !== 1'b0) begin n_err++; $display("FAIL rmid_in_active: got busy=%b cs=%b want 1/0", busy, m_spi_cs); end
        #2 rst = 1'b1;
        #1;
        n_cmp++; if (m_data_in !== 16'h0 || busy !== 1'b0 || zero_cmd !== 1'b0) begin
            n_err++; $display("FAIL rmid_outputs: got mdi=%h busy=%b zero=%b want 0000/0/0", m_data_in, busy, zero_cmd);
        end
        n_cmp++; if (rsp_valid !== 1'b0 || rsp_data !== 16'h0 || rsp_err !== 1'b0 || cmd_ready !== 1'b1) begin
            n_err++; $display("FAIL rmid_fifos: got v=%b %h/%b ready=%b want 0 0000/0 1", rsp_valid, rsp_data, rsp_err, cmd_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        x0 = xfer_count;
        repeat (200) @(negedge clk);
        n_cmp++; if (busy !== 1'b0 || rsp_valid !== 1'b0 || xfer_count - x0 !== 0) begin
            n_err++; $display("FAIL rmid_stays_empty: got busy=%b rsp_valid=%b xfers=%0d want 0/0/0", busy, rsp_valid, xfer_count - x0);
        end
    endtask

    initial begin
        rst = 1'b1;
        cmd_valid = 1'b0; cmd_data = '0; rsp_ready = 1'b0;
        t_cmd_valid = 1'b0; t_cmd_data = '0; t_rsp_ready = 1'b0;
        t_cs = 1'b1; t_spi_data = '0;
        test_reset();
        test_single();
        test_zero_word();
        test_backpressure();
        test_random();
        test_timeout();
        test_late_start();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
